sad_result_arbiter: RTL and testbench
=====================================

# sad_result_arbiter

Sequential arbiter that shares a single SAD comparator and min-SAD register among the eight SAD cores of the motion-estimation array. Each core raises a request when its block search has finished. The arbiter grants requests one per cycle in round-robin order, adds the core's row offset, and keeps the running minimum SAD with its global row/column. It flags completion once all eight cores have reported. It sits between the cores and the display path, replacing the combinational comparator tree with a time-multiplexed one.

## Interface
- NUM_CORES, 8, number of requesting cores (fixed at 8 for this design; pointer is 3 bits)
- SAD_W, 32, SAD value width
- IDX_W, 8, row/column width
- ROW_STRIDE, 8, global row offset per core index (core k adds k*ROW_STRIDE)
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-high reset
- Start  in  1  single-cycle pulse: clear result, begin a new collection
- Req  in  NUM_CORES  per-core result-valid; held with data until Ack seen
- SadIn  in  NUM_CORES*SAD_W  packed SADs, core k at [k*SAD_W +: SAD_W]
- RowIn  in  NUM_CORES*IDX_W  packed local rows (core v0 low byte)
- ColIn  in  NUM_CORES*IDX_W  packed columns (core v1 low byte)
- Ack  out  NUM_CORES  registered one-hot grant pulse, one cycle
- MinSAD  out  SAD_W  current minimum SAD
- MinRow  out  IDX_W  global row of minimum
- MinCol  out  IDX_W  column of minimum
- WinCore  out  3  index of core holding minimum
- Busy  out  1  high in COLLECT
- Done  out  1  high in DONE, held until Start or Rst

## Operation
- States: IDLE, COLLECT, DONE. Reset enters IDLE.
- IDLE: Req ignored. Start -> COLLECT.
- On Start in any state:
  - MinSAD <= all ones; MinRow, MinCol, WinCore <= 0.
  - Reported mask <= 0; RR pointer <= 7.
  - Next state COLLECT.
  - Start during COLLECT aborts and restarts the collection. Start has priority over a grant in the same cycle.
- COLLECT, each cycle:
  - Eligible = Req & ~reported.
  - Grant the first eligible core scanning from pointer+1 upward, mod 8.
  - At the edge: set that core's Ack bit for the next cycle, set its reported bit, and load pointer with the granted index.
  - Compare the granted core's SAD with MinSAD.
  - If no core is eligible, Ack = 0 and nothing changes.
- Global row = RowIn[k] + k*ROW_STRIDE, truncated to IDX_W (8-bit wrap).
- Update rule: replace the minimum if SadIn < MinSAD (unsigned).
- Ties: replace only if the global row is lower, or the row is equal and the column is lower; otherwise keep the existing minimum.
- Grant that completes the reported mask (all ones) -> DONE at the same edge.
- DONE: outputs held, Req ignored, Ack = 0 after the final pulse. Start -> COLLECT.
- A core still asserting Req while its Ack is high, or afterwards, is never granted twice.
- Reset values: Ack=0, MinSAD=0xFFFFFFFF, MinRow=0, MinCol=0, WinCore=0, Busy=0, Done=0, pointer=7, mask=0.

## Timing
- Start sampled at edge e0 -> Busy=1 after e0.
- Req is first sampled at e1; Req high during the Start cycle is not granted at e0.
- Latency: Req sampled at edge n -> Ack high during cycle n+1.
- MinSAD/MinRow/MinCol/WinCore reflect that core's data during cycle n+1.
- At most one grant per cycle. Eight continuously requesting cores -> grants at e1..e8.
- Done=1 and Busy=0 in the cycle after e8, coincident with the last Ack.
- Handshake: core holds Req/SadIn/RowIn/ColIn stable until it sees Ack, then drops Req within one cycle. Data is sampled only at the grant edge.
- Rst asserted mid-collection: all outputs immediately return to reset values, asynchronously. No partial result survives.
- All outputs are registered; no combinational path from Req to Ack.

## Test plan
- Reset then idle: Rst pulse, Req=0xFF with no Start -> Ack stays 0, MinSAD=0xFFFFFFFF, Busy=0, Done=0.
- Full sweep: Start, all Req high, SADs 100,90,80,70,60,50,40,30 for cores 0..7, core7 row 3 col 4:
  - Acks one-hot in order 0..7 over 8 consecutive cycles.
  - Final MinSAD=30, MinRow=59, MinCol=4, WinCore=7, Done=1.
- Round-robin fairness:
  - Cores 2 and 5 request continuously after Start -> Ack order 2 then 5.
  - After that, both are ignored.
  - Late core 0 request is granted next.
  - Done only after all 8 are granted.
- Tie-break: core1 (row0,col2) and core4 (row0,col1), both SAD 0x10, others 0x20:
  - Cores 1 and 4 yield global rows 8 and 32.
  - Result: MinRow=8, MinCol=2, WinCore=1, regardless of grant order.
- Restart/abort: Start, grant 3 cores, Start again -> MinSAD back to 0xFFFFFFFF, mask cleared; a re-request from core 0 is granted again.
- Row wrap and reset mid-op:
  - Core7 local row 210 -> MinRow=10 (266 mod 256).
  - Assert Rst after 4 grants -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/sad_result_arbiter.sv
// Time-multiplexed min-SAD collector: grants one core per cycle in round-robin
// order and keeps the running minimum SAD with its global row/column.
module sad_result_arbiter #(
   parameter int NUM_CORES  = 8,
   parameter int SAD_W      = 32,
   parameter int IDX_W      = 8,
   parameter int ROW_STRIDE = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic [NUM_CORES-1:0]       req_i,
   input  logic [NUM_CORES*SAD_W-1:0] sad_i,
   input  logic [NUM_CORES*IDX_W-1:0] row_i,
   input  logic [NUM_CORES*IDX_W-1:0] col_i,
   output logic [NUM_CORES-1:0]       ack_o,
   output logic [SAD_W-1:0]           min_sad_o,
   output logic [IDX_W-1:0]           min_row_o,
   output logic [IDX_W-1:0]           min_col_o,
   output logic [2:0]                 win_core_o,
   output logic                       busy_o,
   output logic                       done_o
);

   localparam int PTR_W = 3;

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [NUM_CORES-1:0] mask_q, mask_d;
   logic [NUM_CORES-1:0] ack_q, ack_d;
   logic [SAD_W-1:0]     min_sad_q, min_sad_d;
   logic [IDX_W-1:0]     min_row_q, min_row_d;
   logic [IDX_W-1:0]     min_col_q, min_col_d;
   logic [2:0]           win_q, win_d;

   logic [NUM_CORES-1:0] elig;
   logic                 gnt_vld;
   logic [PTR_W-1:0]     gnt_idx;
   logic [PTR_W-1:0]     scan;
   logic [SAD_W-1:0]     sad_sel;
   logic [IDX_W-1:0]     row_glb;
   logic [IDX_W-1:0]     col_sel;
   logic                 better;

   // Scan starts just past the last winner; i == NUM_CORES wraps back to ptr itself.
   always_comb begin
      elig    = req_i & ~mask_q;
      gnt_vld = 1'b0;
      gnt_idx = ptr_q;
      scan    = '0;
      for (int i = 1; i <= NUM_CORES; i++) begin
         scan = ptr_q + PTR_W'(i);
         if (!gnt_vld && elig[scan]) begin
            gnt_vld = 1'b1;
            gnt_idx = scan;
         end
      end
   end

   assign sad_sel = sad_i[gnt_idx*SAD_W +: SAD_W];
   assign col_sel = col_i[gnt_idx*IDX_W +: IDX_W];
   assign row_glb = row_i[gnt_idx*IDX_W +: IDX_W] + IDX_W'(int'(gnt_idx) * ROW_STRIDE);

   // Equal SADs resolve to the lower global row, then the lower column.
   assign better = (sad_sel < min_sad_q) ||
                   ((sad_sel == min_sad_q) &&
                    ((row_glb < min_row_q) ||
                     ((row_glb == min_row_q) && (col_sel < min_col_q))));

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      mask_d    = mask_q;
      ack_d     = '0;
      min_sad_d = min_sad_q;
      min_row_d = min_row_q;
      min_col_d = min_col_q;
      win_d     = win_q;
      if (start_i) begin
         state_d   = COLLECT;
         ptr_d     = '1;
         mask_d    = '0;
         min_sad_d = '1;
         min_row_d = '0;
         min_col_d = '0;
         win_d     = '0;
      end else if (state_q == COLLECT && gnt_vld) begin
         ack_d[gnt_idx]  = 1'b1;
         mask_d[gnt_idx] = 1'b1;
         ptr_d           = gnt_idx;
         if (better) begin
            min_sad_d = sad_sel;
            min_row_d = row_glb;
            min_col_d = col_sel;
            win_d     = gnt_idx;
         end
         if (&mask_d) state_d = DONE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ptr_q     <= '1;
         mask_q    <= '0;
         ack_q     <= '0;
         min_sad_q <= '1;
         min_row_q <= '0;
         min_col_q <= '0;
         win_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         mask_q    <= mask_d;
         ack_q     <= ack_d;
         min_sad_q <= min_sad_d;
         min_row_q <= min_row_d;
         min_col_q <= min_col_d;
         win_q     <= win_d;
      end
   end

   assign ack_o      = ack_q;
   assign min_sad_o  = min_sad_q;
   assign min_row_o  = min_row_q;
   assign min_col_o  = min_col_q;
   assign win_core_o = win_q;
   assign busy_o     = (state_q == COLLECT);
   assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_sad_result_arbiter.sv
// Bench for sad_result_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of the collection.
module tb_sad_result_arbiter;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [7:0]   req;
   logic [255:0] sad;
   logic [63:0]  row, col;
   logic [7:0]   ack_o;
   logic [31:0]  min_sad_o;
   logic [7:0]   min_row_o, min_col_o;
   logic [2:0]   win_core_o;
   logic         busy_o, done_o;

   sad_result_arbiter dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .req_i(req),
      .sad_i(sad), .row_i(row), .col_i(col),
      .ack_o(ack_o), .min_sad_o(min_sad_o), .min_row_o(min_row_o),
      .min_col_o(min_col_o), .win_core_o(win_core_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Model: phase 0 idle, 1 collecting, 2 done
   logic [7:0]  m_ack, m_mask;
   logic [31:0] m_sad;
   logic [7:0]  m_row, m_col;
   logic [2:0]  m_win;
   int          m_ptr, m_state;

   logic [60:0] dut_vec;
   assign dut_vec = {ack_o, min_sad_o, min_row_o, min_col_o, win_core_o, busy_o, done_o};

   localparam logic [60:0] RST_VEC = {8'h00, 32'hFFFF_FFFF, 8'h00, 8'h00, 3'h0, 1'b0, 1'b0};

   function automatic logic [60:0] exp_vec();
      return {m_ack, m_sad, m_row, m_col, m_win, m_state == 1, m_state == 2};
   endfunction

   function automatic void model_clear();
      m_sad = '1; m_row = '0; m_col = '0; m_win = '0;
      m_mask = '0; m_ptr = 7; m_ack = '0;
   endfunction

   function automatic void model_reset();
      model_clear();
      m_state = 0;
   endfunction

   function automatic void model_edge();
      logic [31:0] s;
      logic [7:0]  r, c;
      m_ack = '0;
      if (start) begin
         model_clear();
         m_state = 1;
      end else if (m_state == 1) begin
         for (int i = 1; i <= 8; i++) begin
            int k;
            k = (m_ptr + i) % 8;
            if (req[k] && !m_mask[k]) begin
               s = sad[k*32 +: 32];
               r = 8'((int'(row[k*8 +: 8]) + k * 8) % 256);
               c = col[k*8 +: 8];
               m_ack[k] = 1'b1;
               m_mask[k] = 1'b1;
               m_ptr = k;
               if ({s, r, c} < {m_sad, m_row, m_col}) begin
                  m_sad = s; m_row = r; m_col = c; m_win = 3'(k);
               end
               if (m_mask == 8'hFF) m_state = 2;
               break;
            end
         end
      end
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_core(input int k, input int s, input int r, input int c);
      sad[k*32 +: 32] = 32'(s);
      row[k*8 +: 8]   = 8'(r);
      col[k*8 +: 8]   = 8'(c);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; req = '0; sad = '0; row = '0; col = '0;
      #2;
      vectors++;
      if (dut_vec !== RST_VEC) begin
         miscompares++;
         $display("FAIL reset_values: got %h want %h", dut_vec, RST_VEC);
      end
      rst = 1'b0;
      model_reset();
      req = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         step();
         vectors++;
         if (dut_vec !== exp_vec() || dut_vec !== RST_VEC) begin
            miscompares++;
            $display("FAIL idle_ignores_req cyc %0d: got %h want %h", i, dut_vec, RST_VEC);
         end
      end
   endtask

   task automatic test_sweep();
      for (int k = 0; k < 8; k++) set_core(k, 100 - 10 * k, 0, 0);
      set_core(7, 30, 3, 4);
      req = 8'hFF; start = 1'b1;
      step();
      start = 1'b0;
      vectors++;
      if (dut_vec !== exp_vec() || busy_o !== 1'b1 || ack_o !== 8'h00) begin
         miscompares++;
         $display("FAIL sweep_start: got %h want %h", dut_vec, exp_vec());
      end
      for (int i = 0; i < 8; i++) begin
         step();
         vectors++;
         if (dut_vec !== exp_vec() || ack_o !== 8'(1 << i)) begin
            miscompares++;
            $display("FAIL sweep_ack %0d: got %h want %h", i, dut_vec, exp_vec());
         end
         req = req & ~m_ack;
      end
      vectors++;
      if ({min_sad_o, min_row_o, min_col_o, win_core_o, done_o, busy_o} !==
          {32'd30, 8'd59, 8'd4, 3'd7, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL sweep_result: got sad %0d row %0d col %0d win %0d done %b want 30 59 4 7 1",
                  min_sad_o, min_row_o, min_col_o, win_core_o, done_o);
      end
      req = 8'hFF;
      step();
      vectors++;
      if (dut_vec !== exp_vec() || ack_o !== 8'h00 || done_o !== 1'b1) begin
         miscompares++;
         $display("FAIL sweep_done_hold: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_fairness();
      int ord[5] = '{1, 3, 4, 6, 7};
      req = '0; start = 1'b1;
      step();
      start = 1'b0;
      req = 8'h24;
      step();
      vectors++;
      if (dut_vec !== exp_vec() || ack_o !== 8'h04) begin
         miscompares++;
         $display("FAIL rr_first: got ack %h want 04", ack_o);
      end
      step();
      vectors++;
      if (dut_vec !== exp_vec() || ack_o !== 8'h20) begin
         miscompares++;
         $display("FAIL rr_second: got ack %h want 20", ack_o);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (dut_vec !== exp_vec() || ack_o !== 8'h00) begin
            miscompares++;
            $display("FAIL rr_no_regrant %0d: got ack %h want 00", i, ack_o);
         end
      end
      req = 8'h25;
      step();
      vectors++;
      if (dut_vec !== exp_vec() || ack_o !== 8'h01 || done_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rr_late_core0: got ack %h done %b want 01 0", ack_o, done_o);
      end
      req = 8'hFF;
      for (int j = 0; j < 5; j++) begin
         step();
         vectors++;
         if (dut_vec !== exp_vec() || ack_o !== 8'(1 << ord[j]) || done_o !== (j == 4)) begin
            miscompares++;
            $display("FAIL rr_rest %0d: got ack %h done %b want %h %b",
                     j, ack_o, done_o, 8'(1 << ord[j]), j == 4);
         end
      end
   endtask

   task automatic test_tie();
      for (int run = 0; run < 2; run++) begin
         for (int k = 0; k < 8; k++) set_core(k, 'h20, 0, 0);
         set_core(1, 'h10, 0, 2);
         set_core(4, 'h10, 0, 1);
         req = '0; start = 1'b1;
         step();
         start = 1'b0;
         req = (run == 0) ? 8'hFF : 8'h10;
         for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
               miscompares++;
               $display("FAIL tie_run%0d cyc %0d: got %h want %h", run, i, dut_vec, exp_vec());
            end
            req = (run == 1 && i == 0) ? 8'hEF : (req & ~m_ack);
         end
         vectors++;
         if ({min_sad_o, min_row_o, min_col_o, win_core_o, done_o} !==
             {32'h10, 8'd8, 8'd2, 3'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL tie_result run%0d: got row %0d col %0d win %0d want 8 2 1",
                     run, min_row_o, min_col_o, win_core_o);
         end
      end
   endtask

   task automatic test_restart();
      for (int k = 0; k < 8; k++) set_core(k, $urandom_range(1, 500), $urandom_range(0, 255), $urandom_range(0, 255));
      req = 8'hFF; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         req = req & ~m_ack;
      end
      req = req | 8'h01;
      start = 1'b1;
      step();
      start = 1'b0;
      vectors++;
      if (dut_vec !== exp_vec() || min_sad_o !== 32'hFFFF_FFFF || ack_o !== 8'h00 || busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_clear: got %h want %h", dut_vec, exp_vec());
      end
      step();
      vectors++;
      if (dut_vec !== exp_vec() || ack_o !== 8'h01) begin
         miscompares++;
         $display("FAIL restart_core0: got ack %h want 01", ack_o);
      end
      req = (req & ~m_ack) | 8'h02;
      step();
      vectors++;
      if (dut_vec !== exp_vec() || ack_o !== 8'h02) begin
         miscompares++;
         $display("FAIL restart_core1: got ack %h want 02", ack_o);
      end
   endtask

   task automatic test_wrap_reset();
      for (int k = 0; k < 8; k++) set_core(k, 1000, k, k);
      set_core(7, 5, 210, 9);
      req = 8'hFF; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         req = req & ~m_ack;
      end
      vectors++;
      if (dut_vec !== exp_vec() || min_row_o !== 8'd10 || win_core_o !== 3'd7 || min_col_o !== 8'd9) begin
         miscompares++;
         $display("FAIL row_wrap: got row %0d win %0d col %0d want 10 7 9", min_row_o, win_core_o, min_col_o);
      end
      req = 8'hFF; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         req = req & ~m_ack;
      end
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      vectors++;
      if (dut_vec !== RST_VEC) begin
         miscompares++;
         $display("FAIL async_reset: got %h want %h", dut_vec, RST_VEC);
      end
      rst = 1'b0;
      req = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         step();
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL post_reset_idle %0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      req = '0;
      for (int n = 0; n < 400; n++) begin
         start = ($urandom_range(0, 39) == 0) || (m_state == 0) ||
                 (m_state == 2 && $urandom_range(0, 3) == 0);
         for (int k = 0; k < 8; k++) begin
            if (!req[k] && $urandom_range(0, 2) == 0) begin
               set_core(k, $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 3));
               req[k] = 1'b1;
            end
         end
         step();
         start = 1'b0;
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL random cyc %0d: got %h want %h", n, dut_vec, exp_vec());
         end
         req = req & ~m_ack;
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_fairness();
      test_tie();
      test_restart();
      test_wrap_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
